// File: rtl/mult_share_arbiter_taint_if.sv
// Client request/response and shared-multiplier signals with bitwise taint shadows.
// The arbiter uses the slave modport; clients plus the multiplier sit on master.
interface mult_share_arbiter_taint_if #(
  parameter int WIDTH = 512
);
  logic               req0, req0_t, req1, req1_t;
  logic [WIDTH-1:0]   a0, a0_t, b0, b0_t;
  logic [WIDTH-1:0]   a1, a1_t, b1, b1_t;
  logic               gnt0, gnt0_t, gnt1, gnt1_t;
  logic               done0, done0_t, done1, done1_t;
  logic [2*WIDTH-1:0] result, result_t;
  logic               mul_start, mul_start_t;
  logic [WIDTH-1:0]   mul_multiplier, mul_multiplier_t;
  logic [WIDTH-1:0]   mul_multiplicand, mul_multiplicand_t;
  logic [2*WIDTH-1:0] mul_product, mul_product_t;
  logic               mul_done, mul_done_t;

  modport slave (
    input  req0, req0_t, req1, req1_t,
    input  a0, a0_t, b0, b0_t, a1, a1_t, b1, b1_t,
    input  mul_product, mul_product_t, mul_done, mul_done_t,
    output gnt0, gnt0_t, gnt1, gnt1_t, done0, done0_t, done1, done1_t,
    output result, result_t, mul_start, mul_start_t,
    output mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t
  );

  modport master (
    output req0, req0_t, req1, req1_t,
    output a0, a0_t, b0, b0_t, a1, a1_t, b1, b1_t,
    output mul_product, mul_product_t, mul_done, mul_done_t,
    input  gnt0, gnt0_t, gnt1, gnt1_t, done0, done0_t, done1, done1_t,
    input  result, result_t, mul_start, mul_start_t,
    input  mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t
  );
endinterface

// File: rtl/mult_share_arbiter_taint.sv
// Round-robin sharing of one sequential multiplier between two clients, with
// conservative taint tracking through arbitration and sequencing.
//   state | meaning
//   IDLE  | arbitrate, capture winner operands, pulse gnt
//   ISSUE | pulse mul_start with operands stable
//   WAIT  | wait for mul_done, accumulate its taint
//   RESP  | pulse done to owner
module mult_share_arbiter_taint #(
  parameter int WIDTH = 512
) (
  input logic clk,
  input logic rst,
  mult_share_arbiter_taint_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q;
  logic               last_q, owner_q, ctl_t_q;
  logic [1:0]         gnt_q, gnt_t_q, done_q, done_t_q;
  logic               start_q, start_t_q;
  logic [WIDTH-1:0]   op_a_q, op_a_t_q, op_b_q, op_b_t_q;
  logic [2*WIDTH-1:0] result_q, result_t_q;

  logic any_req, win_d, ctl_cap_d, ctl_acc_d;

  assign any_req   = bus.req0 | bus.req1;
  assign win_d     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
  // Both request taints count: either could have changed who wins.
  assign ctl_cap_d = bus.req0_t | bus.req1_t;
  assign ctl_acc_d = ctl_t_q | bus.mul_done_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      ctl_t_q    <= 1'b0;
      gnt_q      <= '0;
      gnt_t_q    <= '0;
      done_q     <= '0;
      done_t_q   <= '0;
      start_q    <= 1'b0;
      start_t_q  <= 1'b0;
      op_a_q     <= '0;
      op_a_t_q   <= '0;
      op_b_q     <= '0;
      op_b_t_q   <= '0;
      result_q   <= '0;
      result_t_q <= '0;
    end else begin
      gnt_q     <= '0;
      gnt_t_q   <= '0;
      done_q    <= '0;
      done_t_q  <= '0;
      start_q   <= 1'b0;
      start_t_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gnt_t_q <= {2{ctl_cap_d}};
          if (any_req) begin
            state_q  <= ISSUE;
            owner_q  <= win_d;
            last_q   <= win_d;
            gnt_q    <= win_d ? 2'b10 : 2'b01;
            ctl_t_q  <= ctl_cap_d;
            op_a_q   <= win_d ? bus.a1 : bus.a0;
            op_b_q   <= win_d ? bus.b1 : bus.b0;
            op_a_t_q <= ctl_cap_d ? '1 : (win_d ? bus.a1_t : bus.a0_t);
            op_b_t_q <= ctl_cap_d ? '1 : (win_d ? bus.b1_t : bus.b0_t);
          end
        end
        ISSUE: begin
          state_q   <= WAIT;
          start_q   <= 1'b1;
          start_t_q <= ctl_t_q;
        end
        WAIT: begin
          ctl_t_q <= ctl_acc_d;
          if (bus.mul_done) begin
            state_q    <= RESP;
            result_q   <= bus.mul_product;
            result_t_q <= bus.mul_product_t;
            done_q     <= owner_q ? 2'b10 : 2'b01;
            done_t_q   <= {2{ctl_acc_d}};
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0               = gnt_q[0];
  assign bus.gnt1               = gnt_q[1];
  assign bus.gnt0_t             = gnt_t_q[0];
  assign bus.gnt1_t             = gnt_t_q[1];
  assign bus.done0              = done_q[0];
  assign bus.done1              = done_q[1];
  assign bus.done0_t            = done_t_q[0];
  assign bus.done1_t            = done_t_q[1];
  assign bus.mul_start          = start_q;
  assign bus.mul_start_t        = start_t_q;
  assign bus.mul_multiplier     = op_a_q;
  assign bus.mul_multiplier_t   = op_a_t_q;
  assign bus.mul_multiplicand   = op_b_q;
  assign bus.mul_multiplicand_t = op_b_t_q;
  assign bus.result             = result_q;
  assign bus.result_t           = result_t_q;
endmodule

// File: tb/tb_mult_share_arbiter_taint.sv
// Scoreboard bench for mult_share_arbiter_taint with a behavioural multiplier.
module tb_mult_share_arbiter_taint;
  localparam int W   = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_arbiter_taint_if #(.WIDTH(W)) bus ();
  mult_share_arbiter_taint #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int           client;
    logic [W-1:0] a, b, a_t, b_t;
    logic         gnt_t, start_t, done_t;
    logic [2*W-1:0] prod, prod_t;
  } job_t;

  job_t gnt_sb[$];
  job_t done_sb[$];
  job_t cur_j, mon_j;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gnt_cyc = -10;
  int md_cyc  = -10;
  int mcnt    = 0;
  logic prev_start = 1'b0;
  logic [2*W-1:0] mp_t_cfg = '0;
  logic md_t_cfg = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Multiplier model: product valid LAT cycles after start; garbage otherwise.
  always @(negedge clk) begin
    bus.mul_done      = 1'b0;
    bus.mul_done_t    = 1'b0;
    bus.mul_product   = 16'hDEAD;
    bus.mul_product_t = '1;
    if (rst) begin
      mcnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.mul_done      = 1'b1;
          bus.mul_done_t    = md_t_cfg;
          bus.mul_product   = {{W{1'b0}}, bus.mul_multiplier} * {{W{1'b0}}, bus.mul_multiplicand};
          bus.mul_product_t = mp_t_cfg;
          md_cyc = cyc;
        end
      end
      if (bus.mul_start) mcnt = LAT;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt0 | bus.gnt1) begin
        check("gnt_excl", bus.gnt0 & bus.gnt1, 0);
        if (gnt_sb.size() == 0) check("gnt_unexp", 1, 0);
        else begin
          mon_j   = gnt_sb.pop_front();
          cur_j   = mon_j;
          gnt_cyc = cyc;
          check("gnt_client", bus.gnt1, mon_j.client);
          check("gnt_t", {bus.gnt1_t, bus.gnt0_t}, {2{mon_j.gnt_t}});
          check("mul_a", bus.mul_multiplier, mon_j.a);
          check("mul_b", bus.mul_multiplicand, mon_j.b);
          check("mul_a_t", bus.mul_multiplier_t, mon_j.a_t);
          check("mul_b_t", bus.mul_multiplicand_t, mon_j.b_t);
        end
      end
      if (bus.mul_start) begin
        check("start_lat", cyc, gnt_cyc + 1);
        check("start_t", bus.mul_start_t, cur_j.start_t);
        check("start_width", prev_start, 0);
      end
      prev_start = bus.mul_start;
      if (bus.done0 | bus.done1) begin
        check("done_excl", bus.done0 & bus.done1, 0);
        if (done_sb.size() == 0) check("done_unexp", 1, 0);
        else begin
          mon_j = done_sb.pop_front();
          check("done_client", bus.done1, mon_j.client);
          check("done_lat", cyc, md_cyc + 1);
          check("result", bus.result, mon_j.prod);
          check("result_t", bus.result_t, mon_j.prod_t);
          check("done_t", {bus.done1_t, bus.done0_t}, {2{mon_j.done_t}});
          check("op_hold", bus.mul_multiplier, mon_j.a);
        end
      end
    end
  end

  task automatic push_job(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] a_t, input logic [W-1:0] b_t,
                          input logic ctl, input logic dt, input logic [2*W-1:0] pt);
    job_t j;
    j.client  = c;
    j.a       = a;
    j.b       = b;
    j.a_t     = ctl ? '1 : a_t;
    j.b_t     = ctl ? '1 : b_t;
    j.gnt_t   = ctl;
    j.start_t = ctl;
    j.done_t  = ctl | dt;
    j.prod    = 16'(a) * 16'(b);
    j.prod_t  = pt;
    gnt_sb.push_back(j);
    done_sb.push_back(j);
  endtask

  task automatic drive(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] a_t, input logic [W-1:0] b_t);
    if (c == 0) begin
      bus.a0 = a; bus.b0 = b; bus.a0_t = a_t; bus.b0_t = b_t;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.a1_t = a_t; bus.b1_t = b_t;
    end
  endtask

  task automatic serve(input logic r0, input logic r1, input int n_jobs);
    int seen = 0;
    int t    = 0;
    bus.req0 = r0;
    bus.req1 = r1;
    while (seen < n_jobs && t < 40 * n_jobs) begin
      @(posedge clk); #2;
      t++;
      if (bus.done0) seen++;
      if (bus.done1) seen++;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("serve_jobs", seen, n_jobs);
    @(posedge clk); #2;
  endtask

  task automatic check_zero();
    check("rst_ctl", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mul_start,
                      bus.gnt0_t, bus.gnt1_t, bus.done0_t, bus.done1_t, bus.mul_start_t}, 0);
    check("rst_result", {bus.result, bus.result_t}, 0);
    check("rst_ops", {bus.mul_multiplier, bus.mul_multiplier_t,
                      bus.mul_multiplicand, bus.mul_multiplicand_t}, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    int t;
    bus.req0 = 1'b0; bus.req0_t = 1'b0;
    bus.req1 = 1'b0; bus.req1_t = 1'b0;
    drive(0, '0, '0, '0, '0);
    drive(1, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #2;
    check_zero();
    rst = 1'b0;
    @(posedge clk); #2;

    // single client 0
    drive(0, 8'd7, 8'd9, '0, '0);
    push_job(0, 8'd7, 8'd9, '0, '0, 1'b0, 1'b0, '0);
    serve(1'b1, 1'b0, 1);

    // simultaneous requests right after reset: client 0 first
    pulse_reset();
    drive(0, 8'd3, 8'd5, '0, '0);
    drive(1, 8'd4, 8'd6, '0, '0);
    push_job(0, 8'd3, 8'd5, '0, '0, 1'b0, 1'b0, '0);
    push_job(1, 8'd4, 8'd6, '0, '0, 1'b0, 1'b0, '0);
    serve(1'b1, 1'b1, 2);

    // continuous contention alternates
    drive(0, 8'd11, 8'd13, '0, '0);
    drive(1, 8'd2, 8'd200, '0, '0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_job(0, 8'd11, 8'd13, '0, '0, 1'b0, 1'b0, '0);
      else            push_job(1, 8'd2, 8'd200, '0, '0, 1'b0, 1'b0, '0);
    end
    serve(1'b1, 1'b1, 4);

    // tainted idle request taints both grants, then forces operand taint
    bus.req1_t = 1'b1;
    @(posedge clk); #2;
    check("idle_gnt_t", {bus.gnt1_t, bus.gnt0_t}, 2'b11);
    drive(0, 8'd5, 8'd6, '0, '0);
    push_job(0, 8'd5, 8'd6, '0, '0, 1'b1, 1'b0, '0);
    serve(1'b1, 1'b0, 1);
    bus.req1_t = 1'b0;
    @(posedge clk); #2;
    check("idle_gnt_t_clr", {bus.gnt1_t, bus.gnt0_t}, 2'b00);
    drive(0, 8'd2, 8'd3, '0, '0);
    push_job(0, 8'd2, 8'd3, '0, '0, 1'b0, 1'b0, '0);
    serve(1'b1, 1'b0, 1);

    // operand bit taint passes through, product taint mirrored
    drive(0, 8'd9, 8'd10, 8'h01, 8'h00);
    mp_t_cfg = 16'h00A5;
    push_job(0, 8'd9, 8'd10, 8'h01, 8'h00, 1'b0, 1'b0, 16'h00A5);
    serve(1'b1, 1'b0, 1);
    mp_t_cfg = '0;
    drive(0, '0, '0, '0, '0);

    // tainted productDone reaches done_t but not the earlier start
    md_t_cfg = 1'b1;
    drive(0, 8'd12, 8'd12, '0, '0);
    push_job(0, 8'd12, 8'd12, '0, '0, 1'b0, 1'b1, '0);
    serve(1'b1, 1'b0, 1);
    md_t_cfg = 1'b0;

    // client 1 alone at maximum operands
    drive(1, 8'hFF, 8'hFF, 8'h00, 8'h80);
    push_job(1, 8'hFF, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, '0);
    serve(1'b0, 1'b1, 1);

    // reset while waiting on the multiplier
    drive(0, 8'd6, 8'd7, '0, '0);
    push_job(0, 8'd6, 8'd7, '0, '0, 1'b0, 1'b0, '0);
    void'(done_sb.pop_back());
    bus.req0 = 1'b1;
    t = 0;
    while (!bus.mul_start && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    check("start_seen", bus.mul_start, 1);
    rst = 1'b1;
    bus.req0 = 1'b0;
    @(posedge clk); #2;
    check_zero();
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("no_start_after_rst", bus.mul_start, 0);
    push_job(0, 8'd6, 8'd7, '0, '0, 1'b0, 1'b0, '0);
    serve(1'b1, 1'b0, 1);

    check("sb_empty", gnt_sb.size() + done_sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
